// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A)
// and load (B) writeback paths, with one registered output stage.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              WE3,
   output logic [ADDR_W-1:0] AD3,
   output logic [DATA_W-1:0] WD3,
   output logic              last_b,
   output logic [7:0]        drop_cnt
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              xfer;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;

   // Grant: lone requester wins; on contention the port not served last wins.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (rst_n) begin
         if (a_valid && (!b_valid || last_b)) begin
            a_ready = 1'b1;
         end else if (b_valid) begin
            b_ready = 1'b1;
         end
      end
   end

   assign xfer     = a_ready | b_ready;
   assign sel_rd   = b_ready ? b_rd   : a_rd;
   assign sel_data = b_ready ? b_data : a_data;

   // Output stage and pointer; x0 writes are swallowed and counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WE3      <= 1'b0;
         AD3      <= '0;
         WD3      <= '0;
         last_b   <= 1'b1;
         drop_cnt <= '0;
      end else if (xfer) begin
         last_b <= b_ready;
         if (sel_rd != '0) begin
            WE3 <= 1'b1;
            AD3 <= sel_rd;
            WD3 <= sel_data;
         end else begin
            WE3 <= 1'b0;
            if (drop_cnt != CNT_MAX) begin
               drop_cnt <= drop_cnt + CNT_W'(1);
            end
         end
      end else begin
         WE3 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter, checked against a
// transaction-level model of the arbitration rules and an expected register file.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, b_ready;
   logic [4:0]  a_rd = '0, b_rd = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic        WE3;
   logic [4:0]  AD3;
   logic [31:0] WD3;
   logic        last_b;
   logic [7:0]  drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: who was served last, expected write port, drops, register file.
   bit          m_last_was_b = 1'b1;
   bit          m_we = 1'b0;
   logic [4:0]  m_ad = '0;
   logic [31:0] m_wd = '0;
   int          m_drops = 0;
   logic [31:0] rf_model [32] = '{default: '0};
   logic [31:0] rf_obs   [32] = '{default: '0};

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .WE3(WE3), .AD3(AD3), .WD3(WD3), .last_b(last_b), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // The register file being fed: writes land on the edge after WE3 is presented.
   always @(posedge clk) begin
      if (WE3 === 1'b1) rf_obs[AD3] <= WD3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last_was_b = 1'b1;
      m_we = 1'b0;
      m_ad = '0;
      m_wd = '0;
      m_drops = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      #1;
      model_reset();
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd0);
      chk("rst_we3", 32'(WE3), 32'd0);
      chk("rst_ad3", 32'(AD3), 32'd0);
      chk("rst_wd3", WD3, 32'd0);
      chk("rst_last_b", 32'(last_b), 32'd1);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   // One cycle: present requests, check grants, let the edge happen, check outputs.
   task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       output logic obs_ar, output logic obs_br);
      bit want_a, want_b;
      logic [4:0]  rd;
      logic [31:0] d;
      @(negedge clk);
      a_valid = av; a_rd = ar; a_data = ad;
      b_valid = bv; b_rd = br; b_data = bd;
      #1;
      want_a = av && !(bv && !m_last_was_b);
      want_b = bv && !want_a;
      obs_ar = a_ready;
      obs_br = b_ready;
      chk("a_ready", 32'(a_ready), 32'(want_a));
      chk("b_ready", 32'(b_ready), 32'(want_b));
      @(posedge clk);
      if (want_a || want_b) begin
         m_last_was_b = want_b;
         rd = want_b ? br : ar;
         d  = want_b ? bd : ad;
         if (rd == 5'd0) begin
            m_we = 1'b0;
            m_drops = (m_drops + 1 > 255) ? 255 : m_drops + 1;
         end else begin
            m_we = 1'b1;
            m_ad = rd;
            m_wd = d;
            rf_model[rd] = d;
         end
      end else begin
         m_we = 1'b0;
      end
      #1;
      chk("we3", 32'(WE3), 32'(m_we));
      chk("ad3", 32'(AD3), 32'(m_ad));
      chk("wd3", WD3, m_wd);
      chk("last_b", 32'(last_b), 32'(m_last_was_b));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
   endtask

   initial begin
      logic ra, rb;
      logic av_r, bv_r;
      logic [4:0]  ar_r, br_r;
      logic [31:0] ad_r, bd_r, saved9;

      do_reset();

      // Single A write.
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ra, rb);
      chk("t1_a_ready", 32'(ra), 32'd1);
      chk("t1_we3", 32'(WE3), 32'd1);
      chk("t1_ad3", 32'(AD3), 32'd5);
      chk("t1_wd3", WD3, 32'hDEADBEEF);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
      chk("t1_we3_off", 32'(WE3), 32'd0);

      // Contention alternates A, B, A, B with no bubbles.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, ra, rb);
         chk("rr_we3", 32'(WE3), 32'd1);
         chk("rr_ad3", 32'(AD3), (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("rr_last_b", 32'(last_b), 32'(i % 2));
      end

      // Same destination: grant order decides the surviving value.
      do_reset();
      step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, ra, rb);
      chk("same_rd_a_first", 32'(ra), 32'd1);
      step(1'b0, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, ra, rb);
      chk("same_rd_b_second", 32'(rb), 32'd1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
      chk("same_rd_reg7", rf_obs[7], 32'hB);

      // x0 writes accepted but never presented to the register file.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, ra, rb);
         chk("x0_a_ready", 32'(ra), 32'd1);
         chk("x0_we3", 32'(WE3), 32'd0);
      end
      chk("x0_drop_cnt", 32'(drop_cnt), 32'd3);

      // B streams alone, then A joins and wins first.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'(100 + i), ra, rb);
         chk("bstream_b_ready", 32'(rb), 32'd1);
         chk("bstream_we3", 32'(WE3), 32'd1);
      end
      step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, ra, rb);
      chk("a_joins_granted", 32'(ra), 32'd1);
      chk("a_joins_b_waits", 32'(rb), 32'd0);

      // Reset while a write sits in the output stage discards it.
      do_reset();
      step(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
      saved9 = rf_model[9];
      step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, ra, rb);
      rf_model[9] = saved9;
      a_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_we3", 32'(WE3), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_last_b", 32'(last_b), 32'd1);
      chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
      chk("midrst_reg9", rf_obs[9], rf_model[9]);

      // Random traffic: requesters hold until accepted.
      do_reset();
      av_r = 1'b0; bv_r = 1'b0;
      ar_r = '0; br_r = '0; ad_r = '0; bd_r = '0;
      for (int i = 0; i < 300; i++) begin
         if (!av_r && ($urandom % 3 != 0)) begin
            av_r = 1'b1; ar_r = 5'($urandom % 8); ad_r = $urandom;
         end
         if (!bv_r && ($urandom % 3 != 0)) begin
            bv_r = 1'b1; br_r = 5'($urandom % 8); bd_r = $urandom;
         end
         step(av_r, ar_r, ad_r, bv_r, br_r, bd_r, ra, rb);
         if (ra) av_r = 1'b0;
         if (rb) bv_r = 1'b0;
      end
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
      for (int r = 1; r < 8; r++) chk($sformatf("rand_reg%0d", r), rf_obs[r], rf_model[r]);

      // Drop counter saturates.
      do_reset();
      for (int i = 0; i < 260; i++) begin
         step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'(i), ra, rb);
      end
      chk("drop_sat", 32'(drop_cnt), 32'd255);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE3/AD3/WD3) between two writeback requesters: port A (ALU result path) and port B (load/memory result path).
- Round-robin arbitration with valid/ready handshakes.
- One registered output stage drives the write port directly.
- Writes to x0 are accepted and discarded, so the register file never receives a write to register 0.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  A's write accepted this cycle.
- a_rd  input  ADDR_W  A destination register.
- a_data  input  DATA_W  A write data.
- b_valid  input  1  requester B has a write pending.
- b_ready  output  1  B's write accepted this cycle.
- b_rd  input  ADDR_W  B destination register.
- b_data  input  DATA_W  B write data.
- WE3  output  1  register file write enable (registered).
- AD3  output  ADDR_W  register file write address (registered).
- WD3  output  DATA_W  register file write data (registered).
- last_b  output  1  round-robin pointer; 1 = B granted most recently.
- drop_cnt  output  8  count of accepted writes to x0 (saturating).

Behaviour:
- Reset: asynchronous on rst_n low.
  - WE3=0, AD3=0, WD3=0, last_b=1 (A has priority first), drop_cnt=0.
  - a_ready and b_ready are 0 while rst_n is low.
- Grant (combinational from valid and last_b):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A if last_b=1, else grant B.
  - At most one grant per cycle.
  - a_ready = grant A; b_ready = grant B. Ready never asserts without the corresponding valid.
- Handshake:
  - Transfer occurs on the posedge where valid && ready.
  - Requester must hold valid, rd and data stable until its transfer.
  - Losing requester keeps valid high and is granted next cycle (round-robin guarantees this).
  - Starvation bound: one cycle.
- Pointer: on every transfer, last_b <= (granted == B). Unchanged when there is no transfer.
- Output stage, on each posedge:
  - Transfer with rd != 0: WE3<=1, AD3<=rd, WD3<=data of the granted port.
  - Transfer with rd == 0: WE3<=0; AD3/WD3 hold previous values; drop_cnt increments, saturating at 255.
  - No transfer: WE3<=0; AD3/WD3 hold.
- Latency:
  - Transfer at posedge N → WE3/AD3/WD3 valid during cycle N..N+1.
  - Register file writes at posedge N+1.
  - Readers sampling on negedge after N+1 see the new value.
  - One write per cycle sustained throughput, no bubbles.
- Ordering:
  - Simultaneous requests to the same rd are written in grant order; the later grant's value persists.
  - No write merging or reordering.
- Reset mid-operation: a write held in the output stage is discarded (WE3 forced 0); it is not replayed after reset.
- No internal buffering beyond the output stage. The block never deasserts a granted ready within the same cycle.

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=0xDEADBEEF, B idle:
  - a_ready=1 the same cycle.
  - Next cycle WE3=1, AD3=5, WD3=0xDEADBEEF.
  - Following cycle WE3=0.
- Both valid for 4 cycles (A: rd=1, data=0x11; B: rd=2, data=0x22), held until accepted, then re-presented:
  - Grants A, B, A, B.
  - WE3 stays high four consecutive cycles with AD3 sequence 1, 2, 1, 2.
  - last_b toggles 0, 1, 0, 1.
- Both valid, same rd=7 (A data=0xA, B data=0xB) after reset, each deasserting valid after its transfer:
  - A written first, then B.
  - Register 7 ends at 0xB.
- A writes rd=0, data=0xFFFFFFFF, three times:
  - a_ready=1 each cycle.
  - WE3 stays 0 throughout.
  - drop_cnt=3.
- B continuously valid for 5 cycles, A idle:
  - b_ready high all 5 cycles.
  - WE3 high 5 consecutive cycles.
  - Then A asserts with B still valid: A granted first.
- Transfer at posedge N, rst_n pulled low between N and N+1:
  - WE3 falls to 0 asynchronously; no write reaches the register file.
  - After release: last_b=1, drop_cnt=0.
